// File: rtl/grid_pkg.sv
// Shared constants and types for the grid RAM arbiter and its requester bus.
package grid_pkg;

  localparam int unsigned GRID_XW = 6;
  localparam int unsigned GRID_YW = 5;
  localparam int unsigned CELL_W  = 3;
  localparam int unsigned NUM_REQ = 3;

  localparam logic [1:0] REQ_LOADER = 2'd0;
  localparam logic [1:0] REQ_DRAW   = 2'd1;
  localparam logic [1:0] REQ_RAY    = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

  // Round-robin successor of a requester index.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == REQ_RAY) ? REQ_LOADER : idx + 2'd1;
  endfunction

endpackage

// File: rtl/grid_arbiter_if.sv
// Requester-side bus and grid RAM port of the grid arbiter.
interface grid_arbiter_if;
  import grid_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         lock;
  logic [NUM_REQ*GRID_XW-1:0] req_x;
  logic [NUM_REQ*GRID_YW-1:0] req_y;
  logic [NUM_REQ-1:0]         req_we;
  logic [NUM_REQ*CELL_W-1:0]  req_din;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         rvalid;
  logic [CELL_W-1:0]          rdata;
  logic [GRID_XW-1:0]         grid_x;
  logic [GRID_YW-1:0]         grid_y;
  logic                       grid_write;
  logic [CELL_W-1:0]          grid_in;
  logic [CELL_W-1:0]          grid_out;
  logic [1:0]                 owner;

  modport master (
    output req, lock, req_x, req_y, req_we, req_din, grid_out,
    input  gnt, rvalid, rdata, grid_x, grid_y, grid_write, grid_in, owner
  );

  modport slave (
    input  req, lock, req_x, req_y, req_we, req_din, grid_out,
    output gnt, rvalid, rdata, grid_x, grid_y, grid_write, grid_in, owner
  );

endinterface

// File: rtl/grid_arbiter_rr_pick.sv
// Combinational round-robin search: one-hot pick of the first request at or after start.
module rr_pick
  import grid_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         start,
  output logic [NUM_REQ-1:0] pick
);

  localparam int N = int'(NUM_REQ);

  int idx;

  // Walk from farthest to nearest so the requester closest to start wins.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_arbiter.sv
// Round-robin grid RAM arbiter with per-requester burst locking and read-valid tagging.
module grid_arbiter #(
  parameter int unsigned NUM_REQ = grid_pkg::NUM_REQ
) (
  input logic           clock,
  input logic           reset,
  grid_arbiter_if.slave bus
);
  import grid_pkg::*;

  arb_state_e         state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [2:0]         rvalid_q, rvalid_d;
  logic [1:0]         start;
  logic [2:0]         pick;
  logic [2:0]         gnt;
  logic [1:0]         gnt_idx;
  logic               hold;
  logic [GRID_XW-1:0] grid_x;
  logic [GRID_YW-1:0] grid_y;
  logic               grid_write;
  logic [CELL_W-1:0]  grid_in;

  assign hold  = (state_q == StLocked) && bus.req[owner_q] && bus.lock[owner_q];
  // On burst release the search resumes just after the departing owner.
  assign start = (state_q == StLocked) ? rr_next(owner_q) : rr_next(last_q);

  rr_pick u_rr_pick (
    .req   (bus.req),
    .start (start),
    .pick  (pick)
  );

  always_comb begin
    gnt = '0;
    if (reset) begin
      gnt = hold ? (3'b001 << owner_q) : pick;
    end
  end

  always_comb begin
    gnt_idx    = OWNER_NONE;
    grid_x     = '0;
    grid_y     = '0;
    grid_write = 1'b0;
    grid_in    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        gnt_idx    = 2'(i);
        grid_x     = bus.req_x[GRID_XW*i +: GRID_XW];
        grid_y     = bus.req_y[GRID_YW*i +: GRID_YW];
        grid_write = bus.req_we[i];
        grid_in    = bus.req_din[CELL_W*i +: CELL_W];
      end
    end
  end

  always_comb begin
    state_d  = StIdle;
    owner_d  = OWNER_NONE;
    last_d   = last_q;
    rvalid_d = '0;
    if (gnt != '0) begin
      last_d = gnt_idx;
      if (bus.lock[gnt_idx]) begin
        state_d = StLocked;
        owner_d = gnt_idx;
      end
      if (!bus.req_we[gnt_idx]) begin
        rvalid_d = gnt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= OWNER_NONE;
      last_q   <= REQ_RAY;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = bus.grid_out;
  assign bus.owner      = owner_q;
  assign bus.grid_x     = grid_x;
  assign bus.grid_y     = grid_y;
  assign bus.grid_write = grid_write;
  assign bus.grid_in    = grid_in;

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed and random checks of grid_arbiter against a simple arbitration and RAM model.
module tb_grid_arbiter;
  import grid_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  grid_arbiter_if bus ();

  grid_arbiter #(.NUM_REQ(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [2:0] ram     [2048];
  logic [2:0] ref_mem [2048];

  // Grid RAM stand-in: registered read, one cycle of latency.
  always @(posedge clock) begin
    if (bus.grid_write) ram[{bus.grid_x, bus.grid_y}] <= bus.grid_in;
    bus.grid_out <= ram[{bus.grid_x, bus.grid_y}];
  end

  int         total = 0;
  int         bad = 0;
  int         m_owner = 3;
  int         m_last = 2;
  logic [2:0] exp_rvalid = '0;
  logic [2:0] exp_rdata = '0;
  logic [2:0] obs_gnt;
  logic       obs_write;
  logic [2:0] seq [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected grantee for the current inputs, -1 for none.
  function automatic int model_pick();
    int s;
    if (!reset) return -1;
    if (m_owner != 3 && bus.req[m_owner] && bus.lock[m_owner]) return m_owner;
    s = (m_owner != 3) ? m_owner + 1 : m_last + 1;
    for (int k = 0; k < 3; k++) begin
      if (bus.req[(s + k) % 3]) return (s + k) % 3;
    end
    return -1;
  endfunction

  // One clock: check the combinational grant, then the registered results after the edge.
  task automatic cycle();
    int          g;
    logic [10:0] a;
    logic [14:0] port_exp;
    #1;
    g = model_pick();
    obs_gnt   = bus.gnt;
    obs_write = bus.grid_write;
    check("gnt", 32'(bus.gnt), (g < 0) ? 32'd0 : 32'(1 << g));
    port_exp = '0;
    if (g >= 0) begin
      port_exp = {bus.req_x[6*g +: 6], bus.req_y[5*g +: 5], bus.req_we[g],
                  bus.req_din[3*g +: 3]};
    end
    check("grid_port", 32'({bus.grid_x, bus.grid_y, bus.grid_write, bus.grid_in}),
          32'(port_exp));
    @(posedge clock);
    #1;
    exp_rvalid = '0;
    if (!reset) begin
      m_owner = 3;
      m_last  = 2;
    end else if (g >= 0) begin
      m_last  = g;
      m_owner = bus.lock[g] ? g : 3;
      a = {bus.req_x[6*g +: 6], bus.req_y[5*g +: 5]};
      if (bus.req_we[g]) begin
        ref_mem[a] = bus.req_din[3*g +: 3];
      end else begin
        exp_rvalid = 3'(1 << g);
        exp_rdata  = ref_mem[a];
      end
    end else begin
      m_owner = 3;
    end
    check("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
    check("owner", 32'(bus.owner), 32'(m_owner));
    if (exp_rvalid != '0) check("rdata", 32'(bus.rdata), 32'(exp_rdata));
    @(negedge clock);
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    bus.req    = r;
    bus.lock   = l;
    bus.req_we = w;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    seq[0] = 3'b001;
    seq[1] = 3'b010;
    seq[2] = 3'b100;
    seq[3] = 3'b001;
    drive(3'b000, 3'b000, 3'b000);
    bus.req_x   = '0;
    bus.req_y   = '0;
    bus.req_din = '0;

    // Requests during reset must be ignored.
    @(negedge clock);
    drive(3'b111, 3'b111, 3'b010);
    bus.req_x = 18'($urandom);
    bus.req_y = 15'($urandom);
    repeat (2) cycle();
    check("reset_owner", 32'(bus.owner), 32'd3);

    // Plain rotation after reset: requester 0 first.
    reset = 1'b1;
    drive(3'b111, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rotate", 32'(obs_gnt), 32'(seq[i]));
    end

    // Requester 1 writes (5,7)=4, requester 2 reads it back.
    drive(3'b010, 3'b000, 3'b010);
    bus.req_x[11:6] = 6'd5;
    bus.req_y[9:5]  = 5'd7;
    bus.req_din[5:3] = 3'd4;
    cycle();
    check("wr_write", 32'(obs_write), 32'd1);
    drive(3'b100, 3'b000, 3'b000);
    bus.req_x[17:12] = 6'd5;
    bus.req_y[14:10] = 5'd7;
    cycle();
    check("rd_rvalid", 32'(bus.rvalid), 32'h4);
    check("rd_rdata", 32'(bus.rdata), 32'd4);

    // Requester 0 holds a 4-cycle burst against full contention.
    drive(3'b111, 3'b001, 3'b000);
    repeat (4) begin
      cycle();
      check("burst_gnt", 32'(obs_gnt), 32'h1);
      check("burst_owner", 32'(bus.owner), 32'd0);
    end
    drive(3'b111, 3'b000, 3'b000);
    cycle();
    check("release_gnt", 32'(obs_gnt), 32'h2);
    check("release_owner", 32'(bus.owner), 32'd3);

    // Reset lands in the middle of a locked read.
    drive(3'b100, 3'b100, 3'b000);
    cycle();
    #1;
    check("locked_pre", 32'(bus.gnt), 32'h4);
    reset = 1'b0;
    cycle();
    check("abort_gnt", 32'(obs_gnt), 32'h0);
    check("abort_write", 32'(obs_write), 32'h0);
    check("abort_rvalid", 32'(bus.rvalid), 32'h0);
    check("abort_owner", 32'(bus.owner), 32'd3);
    reset = 1'b1;

    // Idle stretch must not disturb the round-robin pointer.
    drive(3'b010, 3'b000, 3'b000);
    cycle();
    drive(3'b000, 3'b000, 3'b000);
    repeat (10) begin
      cycle();
      check("idle_gnt", 32'(obs_gnt), 32'h0);
      check("idle_rvalid", 32'(bus.rvalid), 32'h0);
    end
    drive(3'b111, 3'b000, 3'b000);
    cycle();
    check("idle_last", 32'(obs_gnt), 32'h4);

    // Random traffic; lock bits are biased high so bursts occur often.
    repeat (400) begin
      drive(3'($urandom), 3'($urandom) | 3'($urandom), 3'($urandom));
      bus.req_x   = 18'($urandom);
      bus.req_y   = 15'($urandom);
      bus.req_din = 9'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_arbiter.md
GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 3, number of requesters; index 0 = level loader, 1 = draw grid, 2 = raytracer.
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 Port: req  input  3  per-requester access request, bit i = requester i.
REQ-005 Port: lock  input  3  per-requester burst hold; meaningful only while the matching req bit is 1.
REQ-006 Port: req_x  input  18  requester cell x-coordinates; requester i drives bits [6i+5:6i].
REQ-007 Port: req_y  input  15  requester cell y-coordinates; requester i drives bits [5i+4:5i].
REQ-008 Port: req_we  input  3  per-requester write enable.
REQ-009 Port: req_din  input  9  requester write data; requester i drives bits [3i+2:3i].
REQ-010 Port: gnt  output  3  one-hot grant, or all zeros; combinational in the request cycle.
REQ-011 Port: rvalid  output  3  one-hot; bit i means rdata holds requester i's read result.
REQ-012 Port: rdata  output  3  shared read data; equals grid_out.
REQ-013 Port: grid_x, grid_y, grid_write, grid_in  output  6/5/1/3  to grid RAM.
REQ-014 Port: grid_out  input  3  grid RAM read data; 1-cycle registered read latency.
REQ-015 Port: owner  output  2  index of the locked owner; 3 when no owner.

Function
REQ-016 FSM states SHALL be IDLE (no owner) and LOCKED (owner register valid).
REQ-017 In IDLE, gnt SHALL pick exactly one requesting bit.
- Search is round-robin, starting at (last+1) mod 3.
- last = most recently granted index.
- No requests: gnt = 0.
REQ-018 IDLE->LOCKED SHALL occur at the clock edge where the granted requester has lock = 1; owner <= that index.
REQ-019 In LOCKED, gnt SHALL equal the owner bit whenever req[owner] = 1; all other requests are ignored.
REQ-020 LOCKED->IDLE SHALL occur in any cycle where req[owner] = 0 or lock[owner] = 0.
- Arbitration among the remaining requesters happens in that same cycle, in IDLE fashion.
- The search starts at owner+1.
REQ-021 last SHALL update to the granted index at every edge where gnt != 0.
REQ-022 Grid port SHALL carry the x, y, we and din of the granted requester.
- No grant: all grid outputs are 0.
REQ-023 A granted read (req_we = 0) in cycle t SHALL assert rvalid[i] in cycle t+1, with rdata = grid_out. A granted write produces no rvalid.
REQ-024 Reads and writes SHALL be serviced one per cycle, back-to-back, with no idle cycle between grants.
REQ-025 Coordinates SHALL pass through unmodified; out-of-range values are the requester's responsibility.
REQ-026 A requester that drops req in the same cycle it would be granted SHALL NOT be granted.

Reset
REQ-027 While reset = 0, the following SHALL hold:
- state = IDLE, owner = 3, last = 2 (requester 0 wins first), rvalid = 0.
- gnt = 0 and all grid outputs = 0, regardless of req.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; a pending rvalid is discarded.

Structure
REQ-029 Shared package grid_pkg SHALL hold GRID_XW = 6, GRID_YW = 5, CELL_W = 3, NUM_REQ = 3, requester index constants, and OWNER_NONE = 3.
REQ-030 The round-robin search SHALL be one sub-module, rr_pick, with inputs req[2:0] and start[1:0] and output one-hot pick[2:0]; it is purely combinational.

Verification
REQ-031 After reset release, req = 3'b111, lock = 0 -> gnt sequence 001, 010, 100, 001 on consecutive cycles.
REQ-032 Requester 1 write at (5,7) with din 3'd4, then requester 2 read at (5,7):
- Write cycle: grid_write = 1.
- Read: rvalid = 3'b100 and rdata = 4 one cycle after the read grant.
REQ-033 Requester 0 lock burst of 4 cycles while req = 3'b111:
- gnt = 001 for all 4 cycles; owner = 0.
- Burst ends when lock[0] drops: gnt = 010 in the release cycle; owner = 3.
REQ-034 Reset asserted during a LOCKED read -> same cycle: gnt = 0, grid_write = 0; next cycle: rvalid = 0, owner = 3.
REQ-035 req = 0 for 10 cycles -> gnt = 0, grid outputs 0, rvalid = 0 throughout; last unchanged.
